card_flip_game_ctrl: RTL and testbench

Top-level game sequencer for the 16-card / 8-pair Card-Flip board. It requests a shuffle from the random pair-assignment block through its start/busy handshake, latches the 48-bit card map, and then runs the player turn loop. Each turn flips two cards, holds them visible, and compares their values, then marks the pair matched or hides both. It also tracks moves and matched pairs and flags game over; its outputs drive display logic.

---
 rtl/card_flip_pkg.sv | 29 ++
 rtl/card_flip_rand_if.sv | 13 +
 rtl/card_flip_game_ctrl_turn_timer.sv | 37 +++
 rtl/card_flip_game_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_card_flip_game_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/card_flip_pkg.sv
// Shared types and constants for the Card-Flip game: board geometry, controller
// states and the card-value lookup also used by the display block.
package card_flip_pkg;

  localparam int unsigned N_CARDS = 16;
  localparam int unsigned N_PAIRS = 8;
  localparam int unsigned VAL_W   = 3;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned MAP_W   = N_CARDS * VAL_W;

  typedef enum logic [3:0] {
    IDLE,
    SHUF_REQ,
    SHUF_WAIT_HI,
    SHUF_WAIT_LO,
    PICK1,
    PICK2,
    SHOW,
    RESOLVE,
    OVER
  } state_t;

  // Card i occupies map[3i +: 3].
  function automatic logic [VAL_W-1:0] card_val(input logic [MAP_W-1:0] map,
                                                input logic [IDX_W-1:0] idx);
    return map[int'(idx) * VAL_W +: VAL_W];
  endfunction

endpackage

// File: rtl/card_flip_rand_if.sv
// Shuffle handshake between the game controller (master) and the random
// pair-assignment block (slave): start pulse, busy flag and the 48-bit card map.
interface card_flip_rand_if;
  import card_flip_pkg::*;

  logic             rand_start;
  logic             rand_busy;
  logic [MAP_W-1:0] rand_map;

  modport master (output rand_start, input rand_busy, input rand_map);
  modport slave  (input rand_start, output rand_busy, output rand_map);

endinterface

// File: rtl/card_flip_game_ctrl_turn_timer.sv
// Loadable down-counter with a zero flag; times how long both picked cards
// stay face-up before the turn resolves.
module turn_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/card_flip_game_ctrl.sv
// Card-Flip game sequencer: shuffle handshake, two-pick turn loop, scoring and
// game-over. Optional macro CARD_FLIP_MISS_LIMIT_EN adds a mismatch budget.
module card_flip_game_ctrl
  import card_flip_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned MAX_MISSES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  card_flip_rand_if.master     rnd,
  input  logic                 pick_valid,
  input  logic [IDX_W-1:0]     pick_idx,
  output logic [N_CARDS-1:0]   face_up,
  output logic [N_CARDS-1:0]   matched,
  output logic [MAP_W-1:0]     card_vals,
  output logic [7:0]           moves,
  output logic [3:0]           pairs,
  output logic                 busy,
  output logic                 game_over,
  output logic                 game_won
`ifdef CARD_FLIP_MISS_LIMIT_EN
  ,
  output logic [3:0]           miss_cnt
`endif
);

  localparam int unsigned TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  if (SHOW_CYCLES < 1) begin : g_chk_show
    $error("SHOW_CYCLES must be at least 1");
  end
  if (MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_chk_miss
    $error("MAX_MISSES must fit the 4-bit miss counter (1..15)");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel0_q, sel0_d, sel1_q, sel1_d;
  logic [N_CARDS-1:0] face_q, face_d, matched_q, matched_d;
  logic [MAP_W-1:0]   card_vals_q, card_vals_d;
  logic [7:0]         moves_q, moves_d;
  logic [3:0]         pairs_q, pairs_d;
  logic               refused_q, refused_d;
  logic               rand_start_q, rand_start_d;
  logic               busy_q, busy_d;
  logic               game_over_q, game_over_d;
  logic               game_won_q, game_won_d;
`ifdef CARD_FLIP_MISS_LIMIT_EN
  logic [3:0]         miss_q, miss_d;
`endif

  logic timer_load, timer_dec, timer_zero;

  turn_timer #(.W(TW)) u_show_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (TW'(SHOW_CYCLES - 1)),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    sel0_d      = sel0_q;
    sel1_d      = sel1_q;
    face_d      = face_q;
    matched_d   = matched_q;
    card_vals_d = card_vals_q;
    moves_d     = moves_q;
    pairs_d     = pairs_q;
    refused_d   = refused_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
`ifdef CARD_FLIP_MISS_LIMIT_EN
    miss_d      = miss_q;
`endif

    if (new_game) begin
      // Restart wins over anything else happening this cycle, including a pick.
      state_d   = SHUF_REQ;
      face_d    = '0;
      matched_d = '0;
      moves_d   = '0;
      pairs_d   = '0;
`ifdef CARD_FLIP_MISS_LIMIT_EN
      miss_d    = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        SHUF_REQ: begin
          // Busy already high while we request means the assigner ignored us;
          // wait for its current run to end and the next one to start.
          refused_d = rnd.rand_busy;
          state_d   = SHUF_WAIT_HI;
        end
        SHUF_WAIT_HI: begin
          if (refused_q) begin
            if (!rnd.rand_busy) refused_d = 1'b0;
          end else if (rnd.rand_busy) begin
            state_d = SHUF_WAIT_LO;
          end
        end
        SHUF_WAIT_LO: begin
          if (!rnd.rand_busy) begin
            card_vals_d = rnd.rand_map;
            state_d     = PICK1;
          end
        end
        PICK1: begin
          if (pick_valid && !face_q[pick_idx]) begin
            sel0_d           = pick_idx;
            face_d[pick_idx] = 1'b1;
            state_d          = PICK2;
          end
        end
        PICK2: begin
          if (pick_valid && !face_q[pick_idx]) begin
            sel1_d           = pick_idx;
            face_d[pick_idx] = 1'b1;
            timer_load       = 1'b1;
            state_d          = SHOW;
          end
        end
        SHOW: begin
          if (timer_zero) state_d = RESOLVE;
          else            timer_dec = 1'b1;
        end
        RESOLVE: begin
          moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          if (card_val(card_vals_q, sel0_q) == card_val(card_vals_q, sel1_q)) begin
            matched_d[sel0_q] = 1'b1;
            matched_d[sel1_q] = 1'b1;
            pairs_d           = pairs_q + 4'd1;
            state_d           = (pairs_d == 4'(N_PAIRS)) ? OVER : PICK1;
          end else begin
            face_d[sel0_q] = 1'b0;
            face_d[sel1_q] = 1'b0;
            state_d        = PICK1;
`ifdef CARD_FLIP_MISS_LIMIT_EN
            miss_d = miss_q + 4'd1;
            if (miss_d == 4'(MAX_MISSES)) begin
              face_d  = '1;
              state_d = OVER;
            end
`endif
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end

    // Status outputs are decoded from the next state so they come straight off flops.
    rand_start_d = (state_d == SHUF_REQ);
    busy_d       = (state_d inside {SHUF_REQ, SHUF_WAIT_HI, SHUF_WAIT_LO});
    game_over_d  = (state_d == OVER);
    game_won_d   = (state_d == OVER) && (pairs_d == 4'(N_PAIRS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel0_q       <= '0;
      sel1_q       <= '0;
      face_q       <= '0;
      matched_q    <= '0;
      card_vals_q  <= '0;
      moves_q      <= '0;
      pairs_q      <= '0;
      refused_q    <= 1'b0;
      rand_start_q <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
`ifdef CARD_FLIP_MISS_LIMIT_EN
      miss_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel0_q       <= sel0_d;
      sel1_q       <= sel1_d;
      face_q       <= face_d;
      matched_q    <= matched_d;
      card_vals_q  <= card_vals_d;
      moves_q      <= moves_d;
      pairs_q      <= pairs_d;
      refused_q    <= refused_d;
      rand_start_q <= rand_start_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
`ifdef CARD_FLIP_MISS_LIMIT_EN
      miss_q       <= miss_d;
`endif
    end
  end

  assign rnd.rand_start = rand_start_q;
  assign face_up        = face_q;
  assign matched        = matched_q;
  assign card_vals      = card_vals_q;
  assign moves          = moves_q;
  assign pairs          = pairs_q;
  assign busy           = busy_q;
  assign game_over      = game_over_q;
  assign game_won       = game_won_q;
`ifdef CARD_FLIP_MISS_LIMIT_EN
  assign miss_cnt       = miss_q;
`endif

endmodule

// File: tb/tb_card_flip_game_ctrl.sv
// Self-checking bench for card_flip_game_ctrl: a behavioural assigner plus a
// board-level reference model (card arrays, turn phases) driven by random maps/picks.
module tb_card_flip_game_ctrl;
  import card_flip_pkg::*;

  localparam int SHOW = 4;
  localparam int MAXM = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        pick_valid = 1'b0;
  logic [3:0]  pick_idx = '0;
  logic [15:0] face_up, matched;
  logic [47:0] card_vals;
  logic [7:0]  moves;
  logic [3:0]  pairs;
  logic        busy, game_over, game_won;
`ifdef CARD_FLIP_MISS_LIMIT_EN
  logic [3:0]  miss_cnt;
`endif

  card_flip_rand_if rif ();

  card_flip_game_ctrl #(.SHOW_CYCLES(SHOW), .MAX_MISSES(MAXM)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .rnd        (rif),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx),
    .face_up    (face_up),
    .matched    (matched),
    .card_vals  (card_vals),
    .moves      (moves),
    .pairs      (pairs),
    .busy       (busy),
    .game_over  (game_over),
    .game_won   (game_won)
`ifdef CARD_FLIP_MISS_LIMIT_EN
    ,
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  logic [47:0] next_map = '0;

  // Reference model of the board.
  int        m_vals[16];
  bit [15:0] m_face, m_match;
  int        m_moves, m_pairs, m_misses, m_sel0, m_sel1;
  int        m_phase;  // 0 first pick, 1 second pick, 2 showing, 3 game over
  int        g_vals[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assigner: busy rises the cycle after the start pulse, stays up 20 cycles.
  initial begin
    rif.rand_busy = 1'b0;
    rif.rand_map  = '0;
    forever begin
      @(negedge clk);
      if (rif.rand_start === 1'b1) begin
        @(posedge clk);
        #1 rif.rand_busy = 1'b1;
        repeat (19) begin
          @(posedge clk);
          #1 rif.rand_map = 48'({$urandom(), $urandom()});
        end
        @(posedge clk);
        #1;
        rif.rand_busy = 1'b0;
        rif.rand_map  = next_map;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rif.rand_start === 1'b1) start_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic place(input int pos, input int val, inout bit [15:0] lock);
    int t;
    for (int j = 0; j < 16; j++) begin
      if (!lock[j] && g_vals[j] == val) begin
        t = g_vals[pos]; g_vals[pos] = g_vals[j]; g_vals[j] = t;
        break;
      end
    end
    lock[pos] = 1'b1;
  endtask

  task automatic make_map(input bit constrained, output logic [47:0] map);
    int t, j;
    bit [15:0] lock;
    for (int i = 0; i < 16; i++) g_vals[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i);
      t = g_vals[i]; g_vals[i] = g_vals[j]; g_vals[j] = t;
    end
    if (constrained) begin
      lock = '0;
      place(0, 2, lock);
      place(5, 2, lock);
      place(1, 4, lock);
      place(2, 6, lock);
    end
    for (int i = 0; i < 16; i++) map[3*i +: 3] = 3'(g_vals[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({face_up, matched, card_vals, moves, pairs} !== '0) begin
      n_errors++; $display("FAIL reset_data: got face=%h match=%h vals=%h moves=%0d pairs=%0d required all 0",
                           face_up, matched, card_vals, moves, pairs);
    end
    n_checks++;
    if ({busy, game_over, game_won, rif.rand_start} !== 4'b0) begin
      n_errors++; $display("FAIL reset_flags: got busy/over/won/start=%b required 0000",
                           {busy, game_over, game_won, rif.rand_start});
    end
    reset = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({busy, rif.rand_start, face_up} !== '0) begin
      n_errors++; $display("FAIL idle_hold: got busy=%b start=%b face=%h required idle zeros",
                           busy, rif.rand_start, face_up);
    end
  endtask

  task automatic start_game(input logic [47:0] map, input bit with_pick);
    int steps;
    next_map  = map;
    start_cnt = 0;
    new_game  = 1'b1;
    if (with_pick) begin
      pick_valid = 1'b1;
      pick_idx   = 4'($urandom_range(15));
    end
    step();
    new_game   = 1'b0;
    pick_valid = 1'b0;
    n_checks++;
    if (rif.rand_start !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL shuf_req: got start=%b busy=%b required 1 1", rif.rand_start, busy);
    end
    n_checks++;
    if ({face_up, matched, moves, pairs, game_over, game_won} !== '0) begin
      n_errors++; $display("FAIL new_game_clear: got face=%h match=%h moves=%0d pairs=%0d over=%b required 0",
                           face_up, matched, moves, pairs, game_over);
    end
    steps = 1;
    while (busy === 1'b1 && steps < 200) begin
      step();
      steps++;
    end
    n_checks++;
    if (steps != 23) begin
      n_errors++; $display("FAIL shuf_latency: busy dropped after %0d cycles required 23", steps);
    end
    n_checks++;
    if (card_vals !== map) begin
      n_errors++; $display("FAIL card_map: got %h required %h", card_vals, map);
    end
    n_checks++;
    if (start_cnt != 1) begin
      n_errors++; $display("FAIL start_pulse: rand_start high %0d cycles required 1", start_cnt);
    end
    for (int i = 0; i < 16; i++) m_vals[i] = int'(map[3*i +: 3]);
    m_face = '0; m_match = '0; m_moves = 0; m_pairs = 0; m_misses = 0; m_phase = 0;
  endtask

  task automatic pick(input int idx, input bit poke);
    bit acc;
    pick_idx   = 4'(idx);
    pick_valid = 1'b1;
    step();
    pick_valid = 1'b0;
    acc = (m_phase == 0 || m_phase == 1) && !m_face[idx];
    if (acc) begin
      m_face[idx] = 1'b1;
      if (m_phase == 0) begin m_sel0 = idx; m_phase = 1; end
      else              begin m_sel1 = idx; m_phase = 2; end
    end
    n_checks++;
    if (face_up !== m_face || matched !== m_match) begin
      n_errors++; $display("FAIL pick_%0d: got face=%h match=%h required face=%h match=%h",
                           idx, face_up, matched, m_face, m_match);
    end
    if (m_phase != 2) return;
    for (int k = 0; k < SHOW; k++) begin
      if (poke) begin
        pick_idx   = 4'($urandom_range(15));
        pick_valid = 1'b1;
      end
      step();
      pick_valid = 1'b0;
      n_checks++;
      if (face_up !== m_face || matched !== m_match || moves !== 8'(m_moves)) begin
        n_errors++; $display("FAIL show_hold: got face=%h match=%h moves=%0d required face=%h match=%h moves=%0d",
                             face_up, matched, moves, m_face, m_match, m_moves);
      end
    end
    step();
    m_moves = (m_moves < 255) ? m_moves + 1 : 255;
    if (m_vals[m_sel0] == m_vals[m_sel1]) begin
      m_match[m_sel0] = 1'b1;
      m_match[m_sel1] = 1'b1;
      m_pairs++;
      m_phase = (m_pairs == 8) ? 3 : 0;
    end else begin
      m_face[m_sel0] = 1'b0;
      m_face[m_sel1] = 1'b0;
      m_misses++;
      m_phase = 0;
`ifdef CARD_FLIP_MISS_LIMIT_EN
      if (m_misses == MAXM) begin
        m_phase = 3;
        m_face  = '1;
      end
`endif
    end
    n_checks++;
    if (face_up !== m_face || matched !== m_match) begin
      n_errors++; $display("FAIL resolve_board: got face=%h match=%h required face=%h match=%h",
                           face_up, matched, m_face, m_match);
    end
    n_checks++;
    if (moves !== 8'(m_moves) || pairs !== 4'(m_pairs)) begin
      n_errors++; $display("FAIL resolve_score: got moves=%0d pairs=%0d required moves=%0d pairs=%0d",
                           moves, pairs, m_moves, m_pairs);
    end
    n_checks++;
    if (game_over !== (m_phase == 3) || game_won !== (m_phase == 3 && m_pairs == 8)) begin
      n_errors++; $display("FAIL resolve_over: got over=%b won=%b required over=%b won=%b",
                           game_over, game_won, m_phase == 3, m_phase == 3 && m_pairs == 8);
    end
`ifdef CARD_FLIP_MISS_LIMIT_EN
    n_checks++;
    if (miss_cnt !== 4'(m_misses)) begin
      n_errors++; $display("FAIL miss_cnt: got %0d required %0d", miss_cnt, m_misses);
    end
`endif
  endtask

  task automatic test_match();
    pick(0, 1'b0);
    pick(5, 1'b0);
    n_checks++;
    if (matched !== 16'h0021 || pairs !== 4'd1 || moves !== 8'd1) begin
      n_errors++; $display("FAIL first_match: got match=%h pairs=%0d moves=%0d required 0021 1 1",
                           matched, pairs, moves);
    end
  endtask

  task automatic test_mismatch();
    pick(1, 1'b0);
    pick(2, 1'b0);
    n_checks++;
    if (face_up[2:1] !== 2'b00 || pairs !== 4'd1 || moves !== 8'd2) begin
      n_errors++; $display("FAIL mismatch: got face[2:1]=%b pairs=%0d moves=%0d required 00 1 2",
                           face_up[2:1], pairs, moves);
    end
  endtask

  task automatic test_ignored();
    int p;
    p = 3;
    pick(0, 1'b0);
    pick(3, 1'b0);
    pick(3, 1'b0);
    for (int j = 0; j < 16; j++) if (j != 3 && m_vals[j] == m_vals[3]) p = j;
    pick(p, 1'b1);
  endtask

  task automatic test_win();
    int a, b;
    for (int v = 0; v < 8; v++) begin
      a = -1; b = -1;
      for (int j = 0; j < 16; j++) begin
        if (!m_match[j] && m_vals[j] == v) begin
          if (a < 0) a = j; else b = j;
        end
      end
      if (a >= 0 && b >= 0) begin
        pick(a, 1'b0);
        pick(b, v[0]);
      end
    end
    n_checks++;
    if (game_over !== 1'b1 || game_won !== 1'b1 || pairs !== 4'd8) begin
      n_errors++; $display("FAIL win: got over=%b won=%b pairs=%0d required 1 1 8", game_over, game_won, pairs);
    end
    pick($urandom_range(15), 1'b0);
  endtask

`ifdef CARD_FLIP_MISS_LIMIT_EN
  task automatic test_miss_limit();
    logic [47:0] map;
    int j;
    make_map(1'b0, map);
    start_game(map, 1'b0);
    for (int r = 0; r < 2; r++) begin
      j = 1;
      while (m_vals[j] == m_vals[0]) j++;
      pick(0, 1'b0);
      pick(j, 1'b0);
    end
    n_checks++;
    if (game_over !== 1'b1 || game_won !== 1'b0 || face_up !== 16'hFFFF || miss_cnt !== 4'd2) begin
      n_errors++; $display("FAIL miss_limit: got over=%b won=%b face=%h miss=%0d required 1 0 ffff 2",
                           game_over, game_won, face_up, miss_cnt);
    end
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) pick($urandom_range(15), 1'($urandom_range(1)));
  endtask

  initial begin
    logic [47:0] map;
    test_reset();
    make_map(1'b1, map);
    start_game(map, 1'b0);
    test_match();
    test_mismatch();
    test_ignored();
    test_win();
    make_map(1'b0, map);
    start_game(map, 1'b1);
`ifdef CARD_FLIP_MISS_LIMIT_EN
    test_miss_limit();
    make_map(1'b0, map);
    start_game(map, 1'b0);
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
